// File: rtl/sample_feeder_pkg.sv
// Shared types and widths for the sample_feeder dataset source.
package sample_feeder_pkg;

  localparam int unsigned X_W      = 7;
  localparam int unsigned T_W      = 2;
  localparam int unsigned N_W      = 32;
  localparam int unsigned EPOCH_W  = 16;
  localparam int unsigned SAMPLE_W = 2 * X_W + T_W;

  typedef enum logic [2:0] {
    StIdle,
    StWaitReq,
    StFetch,
    StPresent,
    StFinished
  } state_e;

  // Storage word layout: {x1, x2, t}
  function automatic logic [SAMPLE_W-1:0] pack_sample(input logic [X_W-1:0] x1,
                                                      input logic [X_W-1:0] x2,
                                                      input logic [T_W-1:0] t);
    return {x1, x2, t};
  endfunction

  // Epoch counter saturates instead of wrapping
  function automatic logic [EPOCH_W-1:0] epoch_inc(input logic [EPOCH_W-1:0] e);
    return (&e) ? e : e + EPOCH_W'(1);
  endfunction

endpackage

// File: rtl/sample_ram.sv
// Single-port sample storage: synchronous write, one-cycle registered read.
// Contents are deliberately not reset.
module sample_ram #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = 9,
  parameter int unsigned DW    = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write port and registered read port share one address
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/sample_feeder.sv
// Training-sample source for the perceptron neuron: load samples in IDLE,
// then replay them in order, one per request, wrapping epoch after epoch.
// Optional macro SAMPLE_FEEDER_EPOCH_LIMIT_EN stops feeding after MAX_EPOCHS
// passes and raises timeout; without it timeout stays 0.
module sample_feeder
  import sample_feeder_pkg::*;
#(
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int unsigned MAX_EPOCHS = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [X_W-1:0]     wr_x1,
  input  logic [X_W-1:0]     wr_x2,
  input  logic [T_W-1:0]     wr_t,
  input  logic               clear,
  input  logic               start,
  input  logic               request_flag,
  input  logic               done,
  output logic [N_W-1:0]     n_count,
  output logic [X_W-1:0]     x1,
  output logic [X_W-1:0]     x2,
  output logic [T_W-1:0]     t,
  output logic               data_ready,
  output logic [EPOCH_W-1:0] epoch,
  output logic               busy,
  output logic               finished,
  output logic               overflow,
  output logic               timeout
);

`ifdef SAMPLE_FEEDER_EPOCH_LIMIT_EN
  localparam bit LimitEn = 1'b1;
`else
  localparam bit LimitEn = 1'b0;
`endif

  // Count needs one extra bit to represent a full store of DEPTH samples
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  state_e               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic [EPOCH_W-1:0]   epoch_q, epoch_d;
  logic                 overflow_q, overflow_d;
  logic                 timeout_q, timeout_d;
  logic [X_W-1:0]       x1_q, x2_q;
  logic [T_W-1:0]       t_q;
  logic                 data_ready_q;
  logic                 finished_q;

  logic                 ram_we, ram_re;
  logic [AW-1:0]        ram_addr;
  logic [SAMPLE_W-1:0]  ram_rdata;

  sample_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (SAMPLE_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (pack_sample(wr_x1, wr_x2, wr_t)),
    .rdata (ram_rdata)
  );

  // Next-state, storage access and bookkeeping
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    idx_d      = idx_q;
    epoch_d    = epoch_q;
    overflow_d = overflow_q;
    timeout_d  = timeout_q;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_addr   = idx_q;
    unique case (state_q)
      StIdle: begin
        ram_addr = count_q[AW-1:0];
        if (clear) begin
          count_d = '0;
        end else if (wr_en) begin
          if (count_q < DepthC) begin
            ram_we  = 1'b1;
            count_d = count_q + CW'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
        // A simultaneous clear would leave nothing to feed
        if (start && (count_q != '0) && !clear) begin
          state_d = StWaitReq;
          idx_d   = '0;
          epoch_d = '0;
        end
      end
      StWaitReq: begin
        if (done)              state_d = StFinished;
        else if (request_flag) state_d = StFetch;
      end
      StFetch: begin
        ram_re  = 1'b1;
        state_d = StPresent;
      end
      StPresent: begin
        state_d = StWaitReq;
        if ({1'b0, idx_q} == count_q - CW'(1)) begin
          idx_d   = '0;
          epoch_d = epoch_inc(epoch_q);
          if (LimitEn && ({{(N_W - EPOCH_W){1'b0}}, epoch_d} >= N_W'(MAX_EPOCHS))) begin
            state_d   = StFinished;
            timeout_d = 1'b1;
          end
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      StFinished: begin
        if (start) begin
          state_d   = StWaitReq;
          idx_d     = '0;
          epoch_d   = '0;
          timeout_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      count_q      <= '0;
      idx_q        <= '0;
      epoch_q      <= '0;
      overflow_q   <= 1'b0;
      timeout_q    <= 1'b0;
      x1_q         <= '0;
      x2_q         <= '0;
      t_q          <= '0;
      data_ready_q <= 1'b0;
      finished_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      epoch_q      <= epoch_d;
      overflow_q   <= overflow_d;
      timeout_q    <= timeout_d;
      // Read data is valid during PRESENT; capture it and strobe once
      data_ready_q <= (state_q == StPresent);
      if (state_q == StPresent) {x1_q, x2_q, t_q} <= ram_rdata;
      // Raised one cycle after entering FINISHED, dropped as soon as it is left
      finished_q   <= (state_q == StFinished) && (state_d == StFinished);
    end
  end

  assign n_count    = N_W'(count_q);
  assign x1         = x1_q;
  assign x2         = x2_q;
  assign t          = t_q;
  assign data_ready = data_ready_q;
  assign epoch      = epoch_q;
  assign busy       = (state_q == StWaitReq) || (state_q == StFetch) || (state_q == StPresent);
  assign finished   = finished_q;
  assign overflow   = overflow_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_sample_feeder.sv
// Bench for sample_feeder: directed stimulus, a queue-based reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_sample_feeder;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned MAXE  = 2;
`ifdef SAMPLE_FEEDER_EPOCH_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0, clear = 1'b0, start = 1'b0, request_flag = 1'b0, done = 1'b0;
  logic [6:0]  wr_x1 = '0, wr_x2 = '0;
  logic [1:0]  wr_t = '0;
  logic [31:0] n_count;
  logic [6:0]  x1, x2;
  logic [1:0]  t;
  logic        data_ready, busy, finished, overflow, timeout;
  logic [15:0] epoch;

  sample_feeder #(
    .DEPTH      (DEPTH),
    .MAX_EPOCHS (MAXE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_x1        (wr_x1),
    .wr_x2        (wr_x2),
    .wr_t         (wr_t),
    .clear        (clear),
    .start        (start),
    .request_flag (request_flag),
    .done         (done),
    .n_count      (n_count),
    .x1           (x1),
    .x2           (x2),
    .t            (t),
    .data_ready   (data_ready),
    .epoch        (epoch),
    .busy         (busy),
    .finished     (finished),
    .overflow     (overflow),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: stored samples, served count, run mode (0 idle, 1 run, 2 finished)
  logic [6:0] mx1 [DEPTH];
  logic [6:0] mx2 [DEPTH];
  logic [1:0] mt  [DEPTH];
  int  mcnt, served, m_epoch, md, fin_due;
  bit  movf, mtout, chk_en;
  logic [6:0] ex1, ex2;
  logic [1:0] et;
  int  due_q[$];
  int  n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    due_q.delete();
    mcnt = 0; served = 0; m_epoch = 0; md = 0; fin_due = 0;
    movf = 0; mtout = 0; ex1 = '0; ex2 = '0; et = '0;
  endtask

  function automatic bit lim_hit();
    return LIM && (served + due_q.size() >= int'(MAXE) * mcnt);
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    bit exp_dr;
    int k;
    if (chk_en) begin
      exp_dr = 1'b0;
      if (due_q.size() != 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        exp_dr = 1'b1;
        k = served % mcnt;
        ex1 = mx1[k]; ex2 = mx2[k]; et = mt[k];
        served++;
        m_epoch = served / mcnt;
        if (LIM && served >= int'(MAXE) * mcnt) begin
          md = 2; fin_due = cyc + 1; mtout = 1;
        end
      end
      chk("data_ready", 32'(data_ready), 32'(exp_dr));
      chk("x1", 32'(x1), 32'(ex1));
      chk("x2", 32'(x2), 32'(ex2));
      chk("t", 32'(t), 32'(et));
      chk("n_count", n_count, 32'(mcnt));
      chk("epoch", 32'(epoch), 32'(m_epoch));
      chk("busy", 32'(busy), 32'(md == 1));
      chk("finished", 32'(finished), 32'(md == 2 && cyc >= fin_due));
      chk("overflow", 32'(overflow), 32'(movf));
      chk("timeout", 32'(timeout), 32'(mtout));
    end
  end

  task automatic wr(input logic [6:0] a, input logic [6:0] b, input logic [1:0] c, input bit clr);
    @(negedge clk);
    wr_en = 1'b1; wr_x1 = a; wr_x2 = b; wr_t = c; clear = clr;
    @(posedge clk); #1;
    wr_en = 1'b0; clear = 1'b0;
    if (md == 0) begin
      if (clr) mcnt = 0;
      else if (mcnt < int'(DEPTH)) begin
        mx1[mcnt] = a; mx2[mcnt] = b; mt[mcnt] = c; mcnt++;
      end else movf = 1;
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if ((md == 0 && mcnt != 0) || md == 2) begin
      md = 1; served = 0; m_epoch = 0; mtout = 0; fin_due = 0;
    end
  endtask

  // Single request pulse; returns on the cycle its data_ready is due
  task automatic req();
    @(negedge clk);
    request_flag = 1'b1;
    if (md == 1 && !lim_hit()) due_q.push_back(cyc + 3);
    @(posedge clk); #1;
    request_flag = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Request held for len edges: one sample per three cycles
  task automatic hold(input int len);
    @(negedge clk);
    request_flag = 1'b1;
    for (int j = 0; 3 * j < len; j++)
      if (md == 1 && !lim_hit()) due_q.push_back(cyc + 3 + 3 * j);
    repeat (len) @(posedge clk);
    #1 request_flag = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic done_with(input bit r);
    @(negedge clk);
    done = 1'b1; request_flag = r;
    @(posedge clk); #1;
    done = 1'b0; request_flag = 1'b0;
    if (md == 1) begin md = 2; fin_due = cyc + 1; end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout, expected $finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    logic [6:0] ax1 [4];
    logic [6:0] ax2 [4];
    logic [1:0] at  [4];
    logic [6:0] a, b;
    // (3,-5,+1) (-7,2,-1) (10,-20,+1) (63,-64,-1)
    ax1 = '{7'h03, 7'h79, 7'h0A, 7'h3F};
    ax2 = '{7'h7B, 7'h02, 7'h6C, 7'h40};
    at  = '{2'b01, 2'b11, 2'b01, 2'b11};

    model_reset();
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("lit_reset_n_count", n_count, 32'd0);
    chk("lit_reset_busy", 32'(busy), 32'd0);

    // Start with an empty store is ignored
    do_start();
    @(negedge clk);
    chk("lit_empty_start_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 4; i++) wr(ax1[i], ax2[i], at[i], 1'b0);
    @(negedge clk);
    chk("lit_n_count_4", n_count, 32'd4);

    do_start();
    req();
    chk("lit_first_dr", 32'(data_ready), 32'd1);
    chk("lit_first_x1", 32'(x1), 32'h03);
    chk("lit_first_x2", 32'(x2), 32'h7B);
    chk("lit_first_t", 32'(t), 32'h1);
    repeat (3) req();
    chk("lit_fourth_x1", 32'(x1), 32'h3F);
    chk("lit_fourth_x2", 32'(x2), 32'h40);
    repeat (5) req();
    chk("lit_nine_x1", 32'(x1), 32'h03);
    chk("lit_nine_epoch", 32'(epoch), 32'd2);

    hold(6);
    chk("lit_hold_x1", 32'(x1), 32'h0A);

    // done and request together: done wins
    done_with(1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("lit_finished", 32'(finished), 32'd1);
    chk("lit_finished_dr", 32'(data_ready), 32'd0);

    // Writes and clear are ignored once finished
    wr(7'h11, 7'h22, 2'b01, 1'b0);
    wr(7'h00, 7'h00, 2'b01, 1'b1);
    @(negedge clk);
    chk("lit_fin_n_count", n_count, 32'd4);

    // Retrain restarts from sample 0
    do_start();
    req();
    chk("lit_retrain_x1", 32'(x1), 32'h03);
    chk("lit_retrain_epoch", 32'(epoch), 32'd0);
    req();

    // Reset while in FETCH aborts the transfer
    @(negedge clk);
    request_flag = 1'b1;
    @(posedge clk); #1;
    request_flag = 1'b0;
    #1 rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk("lit_rst_dr", 32'(data_ready), 32'd0);
    chk("lit_rst_n_count", n_count, 32'd0);
    chk("lit_rst_x1", 32'(x1), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // clear beats a simultaneous write
    wr(7'h05, 7'h06, 2'b01, 1'b0);
    wr(7'h07, 7'h08, 2'b11, 1'b0);
    wr(7'h09, 7'h0A, 2'b01, 1'b1);
    @(negedge clk);
    chk("lit_clear_n_count", n_count, 32'd0);

    // DEPTH+1 writes: last one discarded, overflow sticky
    for (int i = 0; i <= int'(DEPTH); i++) begin
      a = 7'(i + 1);
      b = 7'd0 - a;
      wr(a, b, (i % 2 != 0) ? 2'b11 : 2'b01, 1'b0);
    end
    @(negedge clk);
    chk("lit_full_n_count", n_count, 32'(DEPTH));
    chk("lit_overflow", 32'(overflow), 32'd1);
    do_start();
    repeat (DEPTH) req();
    chk("lit_last_x1", 32'(x1), 32'h08);
    req();
    chk("lit_wrap_x1", 32'(x1), 32'h01);
    chk("lit_wrap_epoch", 32'(epoch), 32'd1);
    chk("lit_timeout_off", 32'(timeout), 32'd0);

    if (LIM) begin
      do_reset();
      for (int i = 0; i < 3; i++) wr(ax1[i], ax2[i], at[i], 1'b0);
      do_start();
      hold(30);
      repeat (3) @(negedge clk);
      chk("lit_limit_finished", 32'(finished), 32'd1);
      chk("lit_limit_timeout", 32'(timeout), 32'd1);
      chk("lit_limit_epoch", 32'(epoch), 32'(MAXE));
    end

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sample_feeder.md
# sample_feeder

Hardware dataset source for the perceptron `Neuron` training block, replacing the behavioural sample driver. Stores up to DEPTH training samples (x1, x2, target t) loaded over a simple write port, reports the sample count on `n_count`, and answers each `request_flag` from the neuron with one sample and a one-cycle `data_ready` pulse. Samples are replayed in order and wrap at the end of the set, epoch after epoch, until the neuron raises `done`.

## Interface
- DEPTH, 512: sample storage depth; legal range 1..65536.
- AW, $clog2(DEPTH): storage index width.
- MAX_EPOCHS, 1000: epoch limit; used only with SAMPLE_FEEDER_EPOCH_LIMIT_EN.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write one sample into storage; honoured only in IDLE
- wr_x1, wr_x2  in  7  signed sample inputs
- wr_t  in  2  signed target (+1 / -1)
- clear  in  1  in IDLE, sets count to 0
- start  in  1  begin feeding; honoured only in IDLE
- request_flag  in  1  neuron asks for the next sample
- done  in  1  neuron finished training
- n_count  out  32  samples stored, zero-extended; drives neuron `nInput`
- x1, x2  out  7  signed presented sample
- t  out  2  signed presented target
- data_ready  out  1  one-cycle strobe: x1/x2/t valid
- epoch  out  16  completed passes over the set, saturating at 16'hFFFF
- busy  out  1  high in every state except IDLE and FINISHED
- finished  out  1  high in FINISHED
- overflow  out  1  sticky: write attempted while full
- timeout  out  1  epoch limit reached (0 when macro absent)

## Operation
- States: IDLE, WAIT_REQ, FETCH, PRESENT, FINISHED.
- IDLE: wr_en with count < DEPTH stores at index count, count++. wr_en with count == DEPTH: no write, overflow <= 1. clear has priority over wr_en. start with count != 0 -> WAIT_REQ, idx <= 0, epoch <= 0. start with count == 0 ignored.
- WAIT_REQ: done -> FINISHED (done has priority over request_flag). request_flag -> FETCH.
- FETCH: storage read of idx issued; -> PRESENT.
- PRESENT: x1/x2/t registered from read data, data_ready = 1 for this cycle only; idx <= idx+1, or idx <= 0 and epoch++ when idx == count-1. -> WAIT_REQ. A done arriving in PRESENT does not truncate the pulse; it is acted on in the next WAIT_REQ.
- FINISHED: outputs held; start returns to WAIT_REQ with idx, epoch reset (retrain); clear/wr_en still ignored until rst. rst is the only way back to IDLE.
- x1/x2/t hold their last presented value between pulses.
- request_flag held high over several cycles yields one sample per WAIT_REQ->FETCH->PRESENT trip (one sample per 3 cycles max).
- Storage contents are not cleared by rst; only count is.

## Timing
- Reset (async assert, sync deassert by the integrator): state IDLE, count 0, idx 0, epoch 0, x1/x2/t 0, data_ready 0, busy 0, finished 0, overflow 0, timeout 0.
- request_flag sampled high at edge k (in WAIT_REQ) -> data_ready high between edges k+2 and k+3.
- done sampled at edge k in WAIT_REQ -> finished high after edge k+1; up to 2 extra cycles if in FETCH/PRESENT.
- n_count updates the cycle after an accepted write.
- rst mid-transfer aborts immediately; data_ready drops asynchronously.

## Configuration
- SAMPLE_FEEDER_EPOCH_LIMIT_EN defined: when epoch reaches MAX_EPOCHS at a wrap, enter FINISHED with timeout = 1 instead of WAIT_REQ; the final sample's data_ready still fires.
- Undefined: no limit; timeout tied 0; feeding continues until done.

## Structure
- Shared package: sample widths (X_W = 7, T_W = 2), N_W = 32, EPOCH_W = 16, state enum.
- Sub-module `sample_ram`: DEPTH x 16-bit single-port RAM, synchronous write, registered read (1 cycle); feeder FSM instantiates one.

## Test plan
- Load 4 samples (x1=3, x2=-5, t=1 …), start, pulse request_flag 4 times -> 4 data_ready pulses in load order, each 2 cycles after request; n_count = 4.
- Request 9 times with count 4 -> samples 0,1,2,3,0,1,2,3,0; epoch = 2.
- Write DEPTH+1 samples -> n_count = DEPTH, overflow = 1, last write discarded.
- done and request_flag high together in WAIT_REQ -> no data_ready, finished = 1 next cycle.
- Assert rst during FETCH -> data_ready never fires, all outputs at reset values, n_count = 0.
- With SAMPLE_FEEDER_EPOCH_LIMIT_EN, MAX_EPOCHS = 2, count 3, request held high -> exactly 6 pulses, then finished = 1, timeout = 1.
